// File: rtl/q4_semaforo_fsm.sv
// rtl/q4_semaforo_fsm.sv - timed Moore traffic-light controller for a two-way intersection
//
// Purpose:
//   Runs green -> yellow -> all-red phases for the North-South (NS) and
//   Leste-Oeste (LO) directions. Each green has a minimum and a maximum dwell.
//   Vehicle demand is held in sticky flags, and a maintenance request puts
//   both yellow lamps into flashing mode.
//
// Ports:
//   clk             system clock, rising edge active
//   rst             asynchronous, active-high reset
//   A, B            NS lane sensors (already synchronous to clk)
//   C, D            LO lane sensors (already synchronous to clk)
//   manut           maintenance request, level-sensitive
//   ns_g/ns_y/ns_r  NS lamps
//   lo_g/lo_y/lo_r  LO lamps
//   N_S, L_O        compatibility copies of ns_g / lo_g
//   estado          current state code
module q4_semaforo_fsm #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALL_RED_T = 1,
  parameter int FLASH_T   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       manut,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       lo_g,
  output logic       lo_y,
  output logic       lo_r,
  output logic       N_S,
  output logic       L_O,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    AR_NS = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_LO = 3'd3,
    LO_G  = 3'd4,
    LO_Y  = 3'd5,
    MANUT = 3'd6
  } state_t;

  // Last counter value of each timed dwell (a dwell of T cycles ends at cnt == T-1).
  localparam logic [7:0] AR_LAST    = 8'(ALL_RED_T - 1);
  localparam logic [7:0] Y_LAST     = 8'(YELLOW_T - 1);
  localparam logic [7:0] GMIN_LAST  = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMAX_LAST  = 8'(GREEN_MAX - 1);
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_T - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_ns_q, pend_ns_d;
  logic       pend_lo_q, pend_lo_d;
  logic       blink_q, blink_d;

  logic ns_req, lo_req;
  logic green_min_done, green_max_hit;
  logic ns_release, lo_release;
  logic state_change, in_green;

  assign ns_req = A | B;
  assign lo_req = C | D;

  assign green_min_done = (cnt_q >= GMIN_LAST);
  assign green_max_hit  = (cnt_q == GMAX_LAST);

  // A green yields only when the other side is waiting. It yields early once
  // its own lane is empty, and is forced out at the maximum dwell otherwise.
  assign ns_release = green_min_done && pend_lo_q && (!ns_req || green_max_hit);
  assign lo_release = green_min_done && pend_ns_q && (!lo_req || green_max_hit);

  // Next-state logic. Maintenance overrides every phase transition.
  always_comb begin
    state_d = state_q;
    if (manut) begin
      state_d = MANUT;
    end else begin
      case (state_q)
        AR_NS:   if (cnt_q == AR_LAST) state_d = NS_G;
        NS_G:    if (ns_release)       state_d = NS_Y;
        NS_Y:    if (cnt_q == Y_LAST)  state_d = AR_LO;
        AR_LO:   if (cnt_q == AR_LAST) state_d = LO_G;
        LO_G:    if (lo_release)       state_d = LO_Y;
        LO_Y:    if (cnt_q == Y_LAST)  state_d = AR_NS;
        MANUT:   state_d = AR_NS;
        default: state_d = AR_NS;      // illegal code 7 recovers through all-red
      endcase
    end
  end

  assign state_change = (state_d != state_q);
  assign in_green     = (state_q == NS_G) || (state_q == LO_G);

  // Dwell counter. Greens saturate so that an idle green can hold forever
  // without wrapping. In MANUT the counter wraps at the blink half-period.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (state_change) begin
      cnt_d = 8'd0;
    end else if (in_green && (cnt_q >= GMAX_LAST)) begin
      cnt_d = cnt_q;
    end else if ((state_q == MANUT) && (cnt_q == FLASH_LAST)) begin
      cnt_d = 8'd0;
    end
  end

  // Blink phase. It starts lit on MANUT entry and is forced low elsewhere,
  // so every maintenance episode starts from the same phase.
  always_comb begin
    blink_d = 1'b0;
    if (state_d == MANUT) begin
      if (state_q != MANUT) begin
        blink_d = 1'b1;
      end else if (cnt_q == FLASH_LAST) begin
        blink_d = ~blink_q;
      end else begin
        blink_d = blink_q;
      end
    end
  end

  // Sticky demand. The clear on green entry takes priority over a sensor that
  // is still active on that same edge.
  always_comb begin
    pend_ns_d = pend_ns_q | ns_req;
    pend_lo_d = pend_lo_q | lo_req;
    if ((state_d == NS_G) && (state_q != NS_G)) pend_ns_d = 1'b0;
    if ((state_d == LO_G) && (state_q != LO_G)) pend_lo_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= AR_NS;
      cnt_q     <= 8'd0;
      pend_ns_q <= 1'b0;
      pend_lo_q <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_ns_q <= pend_ns_d;
      pend_lo_q <= pend_lo_d;
      blink_q   <= blink_d;
    end
  end

  // Lamp decode is taken from registers only. Lamps therefore change on the
  // same edge as estado and follow an asynchronous reset immediately.
  always_comb begin
    ns_g = 1'b0;
    ns_y = 1'b0;
    ns_r = 1'b0;
    lo_g = 1'b0;
    lo_y = 1'b0;
    lo_r = 1'b0;
    case (state_q)
      NS_G: begin
        ns_g = 1'b1;
        lo_r = 1'b1;
      end
      NS_Y: begin
        ns_y = 1'b1;
        lo_r = 1'b1;
      end
      LO_G: begin
        lo_g = 1'b1;
        ns_r = 1'b1;
      end
      LO_Y: begin
        lo_y = 1'b1;
        ns_r = 1'b1;
      end
      MANUT: begin
        ns_y = blink_q;
        lo_y = blink_q;
      end
      default: begin
        ns_r = 1'b1;
        lo_r = 1'b1;
      end
    endcase
  end

  assign N_S    = ns_g;
  assign L_O    = lo_g;
  assign estado = state_q;

endmodule

// File: tb/tb_q4_semaforo_fsm.sv
// tb/tb_q4_semaforo_fsm.sv - scoreboard bench for q4_semaforo_fsm
module tb_q4_semaforo_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
  logic       manut = 1'b0;
  logic       ns_g, ns_y, ns_r, lo_g, lo_y, lo_r, N_S, L_O;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int         q_cyc[$];
  string      q_name[$];
  logic [10:0] q_exp[$];
  bit         q_pchk[$];
  logic [1:0] q_pend[$];

  q4_semaforo_fsm dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D),
    .manut  (manut),
    .ns_g   (ns_g),
    .ns_y   (ns_y),
    .ns_r   (ns_r),
    .lo_g   (lo_g),
    .lo_y   (lo_y),
    .lo_r   (lo_r),
    .N_S    (N_S),
    .L_O    (L_O),
    .estado (estado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected {estado, N_S, L_O, ns_g, ns_y, ns_r, lo_g, lo_y, lo_r} for a state.
  function automatic logic [10:0] model(input int st, input bit b);
    logic [5:0] l;
    case (st)
      1:       l = 6'b100001;
      2:       l = 6'b010001;
      4:       l = 6'b001100;
      5:       l = 6'b001010;
      6:       l = {1'b0, b, 1'b0, 1'b0, b, 1'b0};
      default: l = 6'b001001;
    endcase
    return {3'(st), l[5], l[2], l};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string nm, input int st, input bit b,
                            input bit pchk, input logic [1:0] pend);
    q_cyc.push_back(cyc);
    q_name.push_back(nm);
    q_exp.push_back(model(st, b));
    q_pchk.push_back(pchk);
    q_pend.push_back(pend);
  endtask

  task automatic run(input string nm, input int st, input bit b, input int n,
                     input bit pchk, input logic [1:0] pend);
    repeat (n) begin
      expect_now(nm, st, b, pchk, pend);
      step();
    end
  endtask

  // Leaves the DUT in the first cycle of NS_G (cnt = 0) with no demand latched.
  task automatic do_reset();
    A = 0; B = 0; C = 0; D = 0; manut = 0;
    rst = 1;
    step();
    rst = 0;
    step();
  endtask

  // Monitor: the outputs are sampled every negedge and compared against the
  // expectations queued for that cycle.
  always @(negedge clk) begin
    logic [10:0] act;
    logic [1:0]  pend_act;
    act = {estado, N_S, L_O, ns_g, ns_y, ns_r, lo_g, lo_y, lo_r};
    pend_act = {dut.pend_ns_q, dut.pend_lo_q};
    checks++;
    if (ns_g && lo_g) begin
      errors++;
      $display("FAIL both_green cyc=%0d ns_g=%b lo_g=%b required not both 1", cyc, ns_g, lo_g);
    end
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      int         c;
      string      nm;
      logic [10:0] e;
      bit         pc;
      logic [1:0] pe;
      c  = q_cyc.pop_front();
      nm = q_name.pop_front();
      e  = q_exp.pop_front();
      pc = q_pchk.pop_front();
      pe = q_pend.pop_front();
      checks++;
      if (c != cyc) begin
        errors++;
        $display("FAIL %s missed sample: queued for cyc=%0d seen at cyc=%0d", nm, c, cyc);
      end else begin
        if (act !== e) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%b required=%b", nm, cyc, act, e);
        end
        if (pc) begin
          checks++;
          if (pend_act !== pe) begin
            errors++;
            $display("FAIL %s_pend cyc=%0d got=%b required=%b", nm, cyc, pend_act, pe);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    // Reset held 3 cycles, then idle: one AR_NS cycle, then NS_G holds.
    rst = 1;
    step();
    run("reset", 0, 0, 3, 1, 2'b00);
    rst = 0;
    run("idle_ar_ns", 0, 0, 1, 1, 2'b00);
    run("idle_ns_g", 1, 0, 50, 1, 2'b00);

    // Demand switch: C held from NS_G cnt=0.
    do_reset();
    C = 1;
    run("dem_ns_g0", 1, 0, 1, 1, 2'b00);
    run("dem_ns_g", 1, 0, 3, 1, 2'b01);
    run("dem_ns_y", 2, 0, 2, 1, 2'b01);
    run("dem_ar_lo", 3, 0, 1, 1, 2'b01);
    C = 0;
    run("dem_lo_g", 4, 0, 1, 1, 2'b00);

    // Contention: both directions continuously busy, 26-cycle rotation.
    do_reset();
    A = 1;
    C = 1;
    run("con_ns_g", 1, 0, 10, 0, 2'b00);
    run("con_ns_y", 2, 0, 2, 0, 2'b00);
    run("con_ar_lo", 3, 0, 1, 0, 2'b00);
    run("con_lo_g", 4, 0, 10, 0, 2'b00);
    run("con_lo_y", 5, 0, 2, 0, 2'b00);
    run("con_ar_ns", 0, 0, 1, 0, 2'b00);
    run("con_ns_g2", 1, 0, 10, 0, 2'b00);
    run("con_ns_y2", 2, 0, 1, 0, 2'b00);
    A = 0;
    C = 0;

    // Short pulse: D for one cycle at cnt=1, then on to maintenance.
    do_reset();
    run("pul_g0", 1, 0, 1, 1, 2'b00);
    D = 1;
    run("pul_g1", 1, 0, 1, 1, 2'b00);
    D = 0;
    run("pul_g23", 1, 0, 2, 1, 2'b01);
    run("pul_ns_y", 2, 0, 2, 1, 2'b01);
    run("pul_ar_lo", 3, 0, 1, 1, 2'b01);
    A = 1;
    run("pul_lo_g0", 4, 0, 1, 1, 2'b00);
    run("pul_lo_g", 4, 0, 3, 1, 2'b10);

    // Maintenance raised during LO_Y.
    manut = 1;
    A = 0;
    run("man_lo_y", 5, 0, 1, 1, 2'b10);
    run("man_on1", 6, 1, 2, 0, 2'b00);
    run("man_off1", 6, 0, 2, 0, 2'b00);
    run("man_on2", 6, 1, 2, 0, 2'b00);
    run("man_off2", 6, 0, 2, 0, 2'b00);
    manut = 0;
    run("man_last", 6, 1, 1, 0, 2'b00);
    run("man_ar_ns", 0, 0, 1, 0, 2'b00);
    run("man_ns_g", 1, 0, 1, 1, 2'b00);

    // Asynchronous reset between edges in LO_G at cnt=5.
    do_reset();
    D = 1;
    run("ar_g0", 1, 0, 1, 1, 2'b00);
    D = 0;
    run("ar_g", 1, 0, 3, 1, 2'b01);
    run("ar_ns_y", 2, 0, 2, 1, 2'b01);
    run("ar_ar_lo", 3, 0, 1, 1, 2'b01);
    A = 1;
    C = 1;
    run("ar_lo_g0", 4, 0, 1, 1, 2'b00);
    run("ar_lo_g", 4, 0, 4, 1, 2'b11);
    #1;
    rst = 1;
    expect_now("async_rst", 0, 0, 1, 2'b00);
    step();
    A = 0;
    C = 0;
    rst = 0;
    repeat (3) step();

    checks++;
    if (q_cyc.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending required=0", q_cyc.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
